ble_at_responder: RTL

// - Far end of the BLE AT-command link: takes command bytes from a UART RX FIFO, assembles one line up to CR LF, and classifies it.
// - Returns "OK\r\n" or "ERROR\r\n" byte by byte to a UART TX FIFO.
// - Serves as the synthesizable BLE-module model for loopback and FPGA self-test of ble_setup.
// - Exercises ble_setup's OK, ERROR/retry and timeout paths.

---
 rtl/ble_at_pkg.sv | 41 ++++
 rtl/ble_at_responder_if.sv | 20 ++
 rtl/ble_at_line_buffer.sv | 56 +++++
 rtl/ble_at_responder.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/ble_at_pkg.sv
// Shared state encoding, character constants and response ROM for the BLE AT responder.
package ble_at_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_BYTE,
        EVALUATE,
        DELAY,
        SEND_RESP
    } state_t;

    localparam logic [7:0] CHAR_CR   = 8'h0D;
    localparam logic [7:0] CHAR_LF   = 8'h0A;
    localparam logic [7:0] CHAR_A    = 8'h41;
    localparam logic [7:0] CHAR_T    = 8'h54;
    localparam logic [7:0] CHAR_PLUS = 8'h2B;
    localparam logic [7:0] CHAR_O    = 8'h4F;
    localparam logic [7:0] CHAR_K    = 8'h4B;
    localparam logic [7:0] CHAR_E    = 8'h45;
    localparam logic [7:0] CHAR_R    = 8'h52;

    localparam int OK_LEN      = 4;
    localparam int ERR_LEN     = 7;
    localparam int AT_LINE_LEN = 4;

    // "OK\r\n" when ok is set, otherwise "ERROR\r\n"
    function automatic logic [7:0] resp_char(input logic ok, input logic [2:0] idx);
        logic [7:0] r;
        case (idx)
            3'd0:    r = ok ? CHAR_O  : CHAR_E;
            3'd1:    r = ok ? CHAR_K  : CHAR_R;
            3'd2:    r = ok ? CHAR_CR : CHAR_R;
            3'd3:    r = ok ? CHAR_LF : CHAR_O;
            3'd4:    r = CHAR_R;
            3'd5:    r = CHAR_CR;
            default: r = CHAR_LF;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ble_at_responder_if.sv
// RX/TX FIFO handshake bundle between the responder (slave) and the UART FIFOs (master).
interface ble_at_responder_if;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] rx_byte;
    logic       get_rx_byte;
    logic       tx_full;
    logic       byte_ready;
    logic [7:0] resp_byte;

    modport master (
        output rx_valid, rx_ready, rx_byte, tx_full,
        input  get_rx_byte, byte_ready, resp_byte
    );

    modport slave (
        input  rx_valid, rx_ready, rx_byte, tx_full,
        output get_rx_byte, byte_ready, resp_byte
    );
endinterface

// File: rtl/ble_at_line_buffer.sv
// Command line storage: bytes, fill level, overflow flag and CR-LF terminator detection.
module ble_at_line_buffer
    import ble_at_pkg::*;
#(
    parameter int MAX_CMD_LEN = 32,
    parameter int LEN_W       = $clog2(MAX_CMD_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             store,
    input  logic             clear,
    input  logic [7:0]       data,
    output logic [7:0]       byte0,
    output logic [7:0]       byte1,
    output logic [7:0]       byte2,
    output logic [LEN_W-1:0] len,
    output logic             overflow,
    output logic             cr_lf_seen
);
    localparam int IDX_W = $clog2(MAX_CMD_LEN);
    localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(MAX_CMD_LEN);

    logic [7:0] line_mem [MAX_CMD_LEN];
    logic [7:0] last_byte;
    logic       room;

    assign room = (len != FULL_LEN);

    always_ff @(posedge clk) begin
        if (store && room && !clear) begin
            line_mem[len[IDX_W-1:0]] <= data;
        end
    end

    // The previous byte is tracked even after overflow so the terminator is still found
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            len       <= '0;
            overflow  <= 1'b0;
            last_byte <= '0;
        end else if (store) begin
            last_byte <= data;
            if (room) begin
                len <= len + LEN_W'(1);
            end else begin
                overflow <= 1'b1;
            end
        end
    end

    assign byte0      = line_mem[0];
    assign byte1      = line_mem[1];
    assign byte2      = line_mem[2];
    assign cr_lf_seen = (data == CHAR_LF) && (last_byte == CHAR_CR);

endmodule

// File: rtl/ble_at_responder.sv
// Synthesizable BLE-module model: assembles AT command lines from the RX FIFO and answers OK/ERROR.
module ble_at_responder
    import ble_at_pkg::*;
#(
    parameter int MAX_CMD_LEN  = 32,
    parameter int RESP_DELAY   = 16,
    parameter int LINE_TIMEOUT = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              err_inject,
    ble_at_responder_if.slave bus,
    output logic              cmd_done,
    output logic              cmd_ok,
    output logic [7:0]        cmd_count
);
    localparam int LEN_W = $clog2(MAX_CMD_LEN + 1);
    localparam int DLY_W = $clog2(RESP_DELAY + 1);
    localparam int TO_W  = $clog2(LINE_TIMEOUT);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(LINE_TIMEOUT - 1);

    state_t           state, state_next;
    logic [DLY_W-1:0] delay_cnt;
    logic [TO_W-1:0]  timeout_cnt;
    logic [2:0]       resp_idx, last_idx;
    logic             result_ok, line_ok, last_push;
    logic             timeout_run, timeout_hit;
    logic             get_rx_byte, byte_ready, buf_store, buf_clear;
    logic [7:0]       resp_byte, byte0, byte1, byte2;
    logic [LEN_W-1:0] len;
    logic             overflow, cr_lf_seen;

    ble_at_line_buffer #(
        .MAX_CMD_LEN (MAX_CMD_LEN),
        .LEN_W       (LEN_W)
    ) u_line_buffer (
        .clk        (clk),
        .rst        (rst),
        .store      (buf_store),
        .clear      (buf_clear),
        .data       (bus.rx_byte),
        .byte0      (byte0),
        .byte1      (byte1),
        .byte2      (byte2),
        .len        (len),
        .overflow   (overflow),
        .cr_lf_seen (cr_lf_seen)
    );

    assign line_ok = !overflow && !err_inject && (byte0 == CHAR_A) && (byte1 == CHAR_T) &&
                     ((len == LEN_W'(AT_LINE_LEN)) ||
                      ((len > LEN_W'(AT_LINE_LEN)) && (byte2 == CHAR_PLUS)));

    assign last_idx  = result_ok ? 3'(OK_LEN - 1) : 3'(ERR_LEN - 1);
    assign last_push = (state == SEND_RESP) && !bus.tx_full && (resp_idx == last_idx);

    // Timeout only fires from IDLE so an outstanding pop is never orphaned
    assign timeout_run = (len != '0) && !bus.rx_ready &&
                         ((state == WAIT_BYTE) || ((state == IDLE) && enable));
    assign timeout_hit = (state == IDLE) && enable && (len != '0) && (timeout_cnt == TO_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        get_rx_byte = 1'b0;
        byte_ready  = 1'b0;
        buf_store   = 1'b0;
        buf_clear   = 1'b0;
        case (state)
            IDLE: begin
                if (timeout_hit) begin
                    buf_clear = 1'b1;
                end else if (enable && bus.rx_valid && !cmd_done) begin
                    get_rx_byte = 1'b1;
                    state_next  = WAIT_BYTE;
                end
            end
            WAIT_BYTE: begin
                if (bus.rx_ready) begin
                    buf_store  = 1'b1;
                    state_next = cr_lf_seen ? EVALUATE : IDLE;
                end
            end
            EVALUATE: state_next = DELAY;
            DELAY: begin
                if (delay_cnt == DLY_W'(1)) begin
                    state_next = SEND_RESP;
                end
            end
            SEND_RESP: begin
                if (!bus.tx_full) begin
                    byte_ready = 1'b1;
                    if (last_push) begin
                        buf_clear  = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        if (rst) begin
            get_rx_byte = 1'b0;
            byte_ready  = 1'b0;
        end
    end

    assign resp_byte       = byte_ready ? resp_char(result_ok, resp_idx) : 8'h00;
    assign bus.get_rx_byte = get_rx_byte;
    assign bus.byte_ready  = byte_ready;
    assign bus.resp_byte   = resp_byte;

    always_ff @(posedge clk) begin
        if (rst) begin
            delay_cnt <= '0;
            resp_idx  <= '0;
            result_ok <= 1'b0;
        end else begin
            if (state == EVALUATE) begin
                delay_cnt <= DLY_W'(RESP_DELAY);
                result_ok <= line_ok;
            end else if (state == DELAY) begin
                delay_cnt <= delay_cnt - DLY_W'(1);
            end
            if (state != SEND_RESP) begin
                resp_idx <= '0;
            end else if (byte_ready) begin
                resp_idx <= resp_idx + 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            timeout_cnt <= '0;
        end else if ((len == '0) || bus.rx_ready) begin
            timeout_cnt <= '0;
        end else if (timeout_run && (timeout_cnt != TO_LAST)) begin
            timeout_cnt <= timeout_cnt + TO_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_done  <= 1'b0;
            cmd_ok    <= 1'b0;
            cmd_count <= '0;
        end else begin
            cmd_done <= last_push;
            if (last_push) begin
                cmd_ok    <= result_ok;
                cmd_count <= cmd_count + 8'd1;
            end
        end
    end

endmodule
